spi_deserializer: RTL
=====================

# spi_deserializer

Receive-side counterpart of the SPI serializer that drives the attenuator and delay-line chips. Samples the serial bus (SPI_clk, DataBit, Att_CS, Del_CS) with the system clock and reassembles each frame into a parallel word. Reports which chip was addressed and whether the frame was well formed. Sits in loopback/readback paths and in self-checking benches as the bus monitor for the serializer.

## Interface
- DATA_WIDTH, 24, payload bits per frame, MSB first.
- SYNC_STAGES, 2, synchronizer flops per async input (min 2).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- SPI_clk  in  1  serial clock, asynchronous to clk.
- DataBit  in  1  serial data, captured on SPI_clk rising edge.
- Att_CS  in  1  attenuator chip select, active low.
- Del_CS  in  1  delay-line chip select, active low.
- Rx_Data  out  DATA_WIDTH  last good frame; holds until next good frame.
- Rx_Target  out  2  target of last good frame (01 = Att, 10 = Del); same encoding as the serializer's DelAttSelect.
- Rx_Valid  out  1  one-cycle pulse: Rx_Data/Rx_Target updated.
- Rx_Error  out  1  one-cycle pulse: frame rejected.
- Busy  out  1  high while a frame is in progress (state SHIFT).

## Operation
- All four bus inputs pass through SYNC_STAGES flops, then one history flop for edge detection. Edges are evaluated on synchronized values only.
- Internal state: shift register (DATA_WIDTH), bit counter (width clog2(DATA_WIDTH+1)), overflow flag, and latched target.
- The bit counter saturates at DATA_WIDTH. Any further rising SPI_clk sets the overflow flag. Shifting stops once overflow is set.
- States:
  - IDLE:
    - Exactly one CS falls → SHIFT. Latch the target, clear the counter, shift register and overflow flag.
    - Both CS low → WAIT_IDLE, pulse Rx_Error.
  - SHIFT:
    - Each rising SPI_clk: shift register ← {shreg[DATA_WIDTH-2:0], DataBit}; counter+1.
    - Other CS goes low → Rx_Error, WAIT_IDLE.
    - Active CS rises:
      - If count == DATA_WIDTH and no overflow → Rx_Data ← shreg, Rx_Target ← latched target, Rx_Valid pulse.
      - Otherwise → Rx_Error pulse; Rx_Data and Rx_Target unchanged.
      - Either way → IDLE.
  - WAIT_IDLE: stay until both synchronized CS are high → IDLE. No outputs are produced here.
- If the active CS rises in the same synchronized cycle as a rising SPI_clk, the clock edge is ignored. The frame is judged on the prior count.
- Rx_Valid and Rx_Error are never high together.
- Input constraints: SPI_clk high and low phases are each ≥ SYNC_STAGES+2 clk periods. DataBit is stable across that window. The serializer's divided clock satisfies this.

## Timing
- Reset values: Rx_Data 0, Rx_Target 00, Rx_Valid 0, Rx_Error 0, Busy 0, state IDLE. Synchronizers are reset to 1 for CS and 0 for SPI_clk/DataBit.
- Reset mid-frame: partial frame discarded. After rst_n rises with a CS still low, the FSM enters WAIT_IDLE, because the synchronizer reset value of 1 produces a falling edge on the low CS. No Valid is produced for that frame.
- Latency: CS rising first sampled at clk edge k → Rx_Valid/Rx_Error high for the cycle after edge k+SYNC_STAGES+1. That is 3 cycles at default.
- Bit capture latency is the same: SYNC_STAGES+1 clk cycles after the SPI_clk rising edge is sampled.
- Busy rises in the same cycle the FSM enters SHIFT and falls in the cycle Rx_Valid/Rx_Error pulses.
- Back-to-back frames: a new CS fall is accepted in the cycle after returning to IDLE.

## Structure
- Package spi_ser_pkg:
  - target encodings TGT_ATT = 2'b01, TGT_DEL = 2'b10;
  - state enum {IDLE, SHIFT, WAIT_IDLE}.
  - The serializer shares the target encodings.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus history flop. Outputs level, rise and fall. Instantiated for SPI_clk, Att_CS and Del_CS; DataBit uses level only.

## Test plan
- Att_CS low, 24 bits 0x9E6D55 MSB first, CS high → one Rx_Valid, Rx_Data = 0x9E6D55, Rx_Target = 01, no Rx_Error.
- Then Del_CS frame of 0x80F0FE → Rx_Valid, Rx_Data = 0x80F0FE, Rx_Target = 10; Busy low between frames.
- Att frame of 8 bits 0xA5, then CS high → Rx_Error pulse, Rx_Data stays 0x80F0FE, no Rx_Valid. Repeat with 25 bits → Rx_Error.
- Att_CS low, then Del_CS low after 5 bits → Rx_Error; FSM ignores further SPI_clk until both CS high; next valid frame 0x000001 is received correctly.
- rst_n low after 12 bits of an Att frame, released with Att_CS still low, 12 more bits, CS high → outputs 0 throughout, no Valid/Error. The following full frame 0xFFFFFF yields Rx_Valid.
- Active CS rise coincident with a 24th SPI_clk rise → Rx_Error (count 23). Measure Rx_Valid latency = 3 clk cycles from first clk edge sampling CS high.

Source files
------------

// File: rtl/spi_ser_pkg.sv
// rtl/spi_ser_pkg.sv - shared target encodings and FSM states for the SPI serializer/deserializer pair
package spi_ser_pkg;

    localparam logic [1:0] TGT_NONE = 2'b00;
    localparam logic [1:0] TGT_ATT  = 2'b01;
    localparam logic [1:0] TGT_DEL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_IDLE = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with history flop and registered edge pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Edge pulses are registered so they line up with level (the history flop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_out;
            rise_q <= sync_out & ~hist_q;
            fall_q <= ~sync_out & hist_q;
        end
    end

    assign level = hist_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_deserializer.sv
// rtl/spi_deserializer.sv - SPI bus monitor that rebuilds attenuator/delay-line frames into parallel words
module spi_deserializer
    import spi_ser_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SPI_clk,
    input  logic                  DataBit,
    input  logic                  Att_CS,
    input  logic                  Del_CS,
    output logic [DATA_WIDTH-1:0] Rx_Data,
    output logic [1:0]            Rx_Target,
    output logic                  Rx_Valid,
    output logic                  Rx_Error,
    output logic                  Busy
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int SETTLE = SYNC_STAGES + 2;
    localparam int ST_W   = $clog2(SETTLE + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall_unused;
    logic att_level, att_rise, att_fall;
    logic del_level, del_rise, del_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SPI_clk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_att (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (Att_CS),
        .level (att_level),
        .rise  (att_rise),
        .fall  (att_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_del (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (Del_CS),
        .level (del_level),
        .rise  (del_rise),
        .fall  (del_fall)
    );

    // Data takes the same path length as the edge pulses so the bit aligns with sclk_rise.
    logic [SYNC_STAGES:0] data_q;
    logic                 data_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= {data_q[SYNC_STAGES-1:0], DataBit};
        end
    end

    assign data_level = data_q[SYNC_STAGES];

    // Until the synchronizers have flushed their reset values, a CS fall is stale.
    logic [ST_W-1:0] settle_cnt;
    logic            settled;

    assign settled = (settle_cnt == ST_W'(SETTLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + ST_W'(1);
        end
    end

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  ovf, ovf_nxt;
    logic [1:0]            tgt, tgt_nxt;
    logic                  valid_nxt, error_nxt, load;
    logic                  active_rise, other_level;

    assign active_rise = (tgt == TGT_ATT) ? att_rise  : del_rise;
    assign other_level = (tgt == TGT_ATT) ? del_level : att_level;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        tgt_nxt   = tgt;
        valid_nxt = 1'b0;
        error_nxt = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (att_fall || del_fall) begin
                    if (!settled) begin
                        state_nxt = WAIT_IDLE;
                    end else if (!att_level && !del_level) begin
                        state_nxt = WAIT_IDLE;
                        error_nxt = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                        tgt_nxt   = att_fall ? TGT_ATT : TGT_DEL;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
            end
            SHIFT: begin
                if (!other_level) begin
                    state_nxt = WAIT_IDLE;
                    error_nxt = 1'b1;
                end else if (active_rise) begin
                    // A clock edge coincident with CS release is dropped on purpose.
                    state_nxt = IDLE;
                    if (cnt == CNT_W'(DATA_WIDTH) && !ovf) begin
                        valid_nxt = 1'b1;
                        load      = 1'b1;
                    end else begin
                        error_nxt = 1'b1;
                    end
                end else if (sclk_rise && !ovf) begin
                    if (cnt == CNT_W'(DATA_WIDTH)) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        shreg_nxt = {shreg[DATA_WIDTH-2:0], data_level};
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            WAIT_IDLE: begin
                if (att_level && del_level) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            tgt       <= TGT_NONE;
            Rx_Data   <= '0;
            Rx_Target <= TGT_NONE;
            Rx_Valid  <= 1'b0;
            Rx_Error  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            ovf      <= ovf_nxt;
            tgt      <= tgt_nxt;
            Rx_Valid <= valid_nxt;
            Rx_Error <= error_nxt;
            if (load) begin
                Rx_Data   <= shreg;
                Rx_Target <= tgt;
            end
        end
    end

    assign Busy = (state == SHIFT);

endmodule
